seq_pattern_detector: RTL and testbench
=======================================

# seq_pattern_detector

Parametrised serial pattern detector, successor to the fixed two-zero sequence detector in the finite-state-machine lab set. It samples one serial bit per enabled clock and tracks the longest prefix of a run-time-loadable LEN-bit pattern that is currently matched. It asserts a Moore-style `detected` flag and supports overlapping or non-overlapping detection. An optional saturating counter records how many detections have occurred.

## Interface
- `LEN`, 4, pattern length in bits; legal range 2..16.
- `CNT_W`, 8, width of the detection counter.
- `ML_W`, $clog2(LEN+1), width of `match_len`. This is a localparam and is not overridable.

- `clk`  in  1  rising-edge clock; the block has one clock.
- `rst`  in  1  reset, synchronous and active-high.
- `en`  in  1  when high, `seq` is sampled on this edge.
- `seq`  in  1  serial input bit.
- `pat_load`  in  1  when high, `pattern` is latched on this edge.
- `pattern`  in  LEN  pattern to detect. `pattern[LEN-1]` is the first bit in time; `pattern[0]` is the last.
- `overlap`  in  1  1 = overlapping detection, 0 = non-overlapping; sampled each enabled cycle.
- `detected`  out  1  high while `match_len == LEN`.
- `match_len`  out  ML_W  number of pattern bits currently matched, 0..LEN.
- `det_count`  out  CNT_W  number of detections, saturating.
- `count_sat`  out  1  sticky flag, set when `det_count` reaches all-ones.

## Operation
- **Internal state:**
  - `pat_r`: the latched pattern.
  - `hist`: the LEN most recent samples, newest in bit 0.
  - `fill`: the number of valid history bits, 0..LEN, saturating.
- **Sample step** (`en=1`, `pat_load=0`):
  - `hist <= {hist[LEN-2:0], seq}`.
  - `fill <= min(fill+1, LEN)`.
- **match_len update:** on the same edge, `match_len` is loaded with the largest k ≤ new `fill` for which the new `hist[k-1:0]` equals `pat_r[LEN-1:LEN-k]`; k=0 if no such k exists. This makes `match_len` exactly the state of the equivalent prefix-matching FSM, with LEN+1 states.
- **Overlapping mode** (`overlap=1`): history is kept across a detection.
  - Example: pattern 0000 stays detected while zeros continue, which generalises the original 00 behaviour.
- **Non-overlapping mode** (`overlap=0`): a sample accepted while `detected=1` discards the old history.
  - `fill <= 1`, so only the new bit is considered.
  - `match_len` becomes 1 if `seq == pat_r[LEN-1]`, otherwise 0.
- **Counting:** a detection event is any accepted sample whose new `match_len` equals LEN. Each event does `det_count <= det_count+1`; the counter holds at all-ones once reached, and `count_sat` is set.
- **Pattern load** (`pat_load=1`):
  - `pat_r <= pattern`.
  - `hist`, `fill`, `match_len` and `detected` are cleared; `det_count` and `count_sat` are retained.
- **Priority:** `rst` > `pat_load` > `en`.
  - When `pat_load` and `en` are both high, the sample is discarded.
- **Hold:** when `en=0` and `pat_load=0`, all state holds.
- **Reset values:**
  - `pat_r` = all zeros, so by default the block detects a run of LEN zeros.
  - `hist` = 0, `fill` = 0, `match_len` = 0, `detected` = 0, `det_count` = 0, `count_sat` = 0.

## Timing
- All outputs are registered.
  - The response to the sample taken on edge N is visible after edge N.
  - Latency is 1 cycle from sample to `match_len`, `detected` and `det_count`.
- `detected` is a decode of registered `match_len`; it is glitch-free and contains no combinational path from `seq`.
- `detected` stays high across `en=0` gaps.
- After reset or `pat_load`, the earliest possible detection is the edge of the LEN-th accepted sample.
- `rst` asserted mid-match: the next edge returns every output to its reset value, regardless of `en` and `pat_load`.
- Wrap-around: `det_count` never wraps.

## Configuration
- `SEQ_DET_COUNT_EN` defined: the `det_count` and `count_sat` logic is built as described above.
- `SEQ_DET_COUNT_EN` undefined:
  - No counter registers are built.
  - `det_count` is tied to 0 and `count_sat` is tied to 0.
  - Ports are unchanged, and detection behaviour is identical.

## Test plan
- Reset default, LEN=4, `overlap=1`, `en=1`, samples 0,0,0,0,0,1 -> `match_len` 1,2,3,4,4,0; `detected` high after the 4th and 5th samples; `det_count`=2.
- Load 1011, `overlap=1`, samples 1,0,1,1,0,1,1 -> `match_len` 1,2,3,4,2,3,4; `det_count`=2.
- Load 1011, `overlap=0`, same samples -> `match_len` 1,2,3,4,0,1,1; `det_count`=1.
- Load 1011, feed 1,0,1, then `en=0` for 3 cycles -> `match_len` holds at 3. Then assert `pat_load` and `en` together with `seq`=1 -> `match_len`=0 and the sample is ignored; `det_count` is unchanged.
- CNT_W=2, pattern 0000, `overlap=1`, 10 zero samples -> 7 detection events; `det_count`=3 (saturated); `count_sat`=1 from the 6th sample onward.
- Mid-match reset: load 1011, feed 1,0,1, then assert `rst` for 1 cycle -> all outputs 0 and `pat_r`=0000. Then 4 zeros -> `detected`=1.

Source files
------------

// File: rtl/seq_pattern_detector_if.sv
// Bus bundle for seq_pattern_detector: sample/load controls in, match status out.
// The master drives the controls; the slave (the detector) drives the status.
interface seq_pattern_detector_if #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned ML_W = $clog2(LEN + 1);

  logic             en;
  logic             seq;
  logic             pat_load;
  logic [LEN-1:0]   pattern;
  logic             overlap;
  logic             detected;
  logic [ML_W-1:0]  match_len;
  logic [CNT_W-1:0] det_count;
  logic             count_sat;

  modport master (
    output en, seq, pat_load, pattern, overlap,
    input  detected, match_len, det_count, count_sat
  );

  modport slave (
    input  en, seq, pat_load, pattern, overlap,
    output detected, match_len, det_count, count_sat
  );
endinterface

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with a run-time loadable LEN-bit pattern.
// match_len is the state of the equivalent prefix-matching FSM (LEN+1 states), recomputed
// each accepted sample from the sample history. Optional saturating detection counter is
// built only when SEQ_DET_COUNT_EN is defined; otherwise det_count/count_sat read as 0.
module seq_pattern_detector #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  seq_pattern_detector_if.slave bus
);
  localparam int unsigned ML_W = $clog2(LEN + 1);
  localparam logic [ML_W-1:0] len_ml = ML_W'(LEN);

  logic [LEN-1:0]  pat_r;
  logic [LEN-1:0]  hist;
  logic [LEN-1:0]  hist_nxt;
  logic [ML_W-1:0] fill;
  logic [ML_W-1:0] fill_nxt;
  logic [ML_W-1:0] match_len;
  logic [ML_W-1:0] ml_nxt;
  logic            drop;
  logic            hit;
  logic            sample;
  logic            det_event;

  // Next history/fill for an accepted sample, and the longest matched pattern prefix.
  always_comb begin
    drop     = ~bus.overlap && (match_len == len_ml);
    hist_nxt = {hist[LEN-2:0], bus.seq};
    fill_nxt = (fill == len_ml) ? len_ml : fill + 1'b1;
    // Non-overlapping: a sample taken while detected starts a fresh history.
    if (drop) begin
      hist_nxt = {{(LEN-1){1'b0}}, bus.seq};
      fill_nxt = ML_W'(1);
    end
    ml_nxt = '0;
    hit    = 1'b0;
    // Ascending k so the largest matching prefix length wins.
    for (int k = 1; k <= LEN; k++) begin
      hit = (ML_W'(k) <= fill_nxt);
      for (int j = 0; j < k; j++) begin
        if (hist_nxt[j] != pat_r[LEN-k+j]) hit = 1'b0;
      end
      if (hit) ml_nxt = ML_W'(k);
    end
  end

  assign sample    = bus.en && !bus.pat_load;
  assign det_event = sample && (ml_nxt == len_ml);

  // Pattern, history and match state; rst beats pat_load beats en.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r     <= '0;
      hist      <= '0;
      fill      <= '0;
      match_len <= '0;
    end else if (bus.pat_load) begin
      pat_r     <= bus.pattern;
      hist      <= '0;
      fill      <= '0;
      match_len <= '0;
    end else if (bus.en) begin
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      match_len <= ml_nxt;
    end
  end

  assign bus.match_len = match_len;
  // Decode of a register only, so no path from seq.
  assign bus.detected  = (match_len == len_ml);

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] det_count;
  logic [CNT_W-1:0] cnt_inc;
  logic             count_sat;

  assign cnt_inc = det_count + 1'b1;

  // Saturating detection counter; survives pattern loads, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      det_count <= '0;
      count_sat <= 1'b0;
    end else if (det_event && (det_count != '1)) begin
      det_count <= cnt_inc;
      if (cnt_inc == '1) count_sat <= 1'b1;
    end
  end

  assign bus.det_count = det_count;
  assign bus.count_sat = count_sat;
`else
  logic unused_det_event;
  assign unused_det_event = det_event;
  assign bus.det_count    = {CNT_W{1'b0}};
  assign bus.count_sat    = 1'b0;
`endif
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: table of per-edge vectors on a LEN=4/CNT_W=8
// instance, plus a saturation sequence on a LEN=4/CNT_W=2 instance.
module tb_seq_pattern_detector;
`ifdef SEQ_DET_COUNT_EN
  localparam bit count_en = 1'b1;
`else
  localparam bit count_en = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  seq_pattern_detector_if #(.LEN(4), .CNT_W(8)) bus_a ();
  seq_pattern_detector_if #(.LEN(4), .CNT_W(2)) bus_b ();

  seq_pattern_detector #(.LEN(4), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  seq_pattern_detector #(.LEN(4), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       seq;
    logic       pl;
    logic [3:0] pat;
    logic       ov;
    int         ml;
    int         det;
    int         cnt;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic v(input logic r, input logic e, input logic s, input logic pl,
                   input logic [3:0] pat, input logic ov, input int ml, input int det,
                   input int cnt);
    vec_t x;
    x.rst = r; x.en = e; x.seq = s; x.pl = pl; x.pat = pat; x.ov = ov;
    x.ml = ml; x.det = det; x.cnt = cnt;
    vecs.push_back(x);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.en = 1'b0; bus_a.seq = 1'b0; bus_a.pat_load = 1'b0;
    bus_a.pattern = 4'h0; bus_a.overlap = 1'b1;
    bus_b.en = 1'b0; bus_b.seq = 1'b0; bus_b.pat_load = 1'b0;
    bus_b.pattern = 4'h0; bus_b.overlap = 1'b1;

    // rst en seq pl pat ov | ml det cnt
    v(1, 0, 0, 0, 4'h0, 1, 0, 0, 0);
    // default pattern 0000, overlapping
    v(0, 1, 0, 0, 4'h0, 1, 1, 0, 0);
    v(0, 1, 0, 0, 4'h0, 1, 2, 0, 0);
    v(0, 1, 0, 0, 4'h0, 1, 3, 0, 0);
    v(0, 1, 0, 0, 4'h0, 1, 4, 1, 1);
    v(0, 1, 0, 0, 4'h0, 1, 4, 1, 2);
    v(0, 1, 1, 0, 4'h0, 1, 0, 0, 2);
    // 1011 overlapping
    v(0, 0, 0, 1, 4'hB, 1, 0, 0, 2);
    v(0, 1, 1, 0, 4'h0, 1, 1, 0, 2);
    v(0, 1, 0, 0, 4'h0, 1, 2, 0, 2);
    v(0, 1, 1, 0, 4'h0, 1, 3, 0, 2);
    v(0, 1, 1, 0, 4'h0, 1, 4, 1, 3);
    v(0, 1, 0, 0, 4'h0, 1, 2, 0, 3);
    v(0, 1, 1, 0, 4'h0, 1, 3, 0, 3);
    v(0, 1, 1, 0, 4'h0, 1, 4, 1, 4);
    // 1011 non-overlapping
    v(0, 0, 0, 1, 4'hB, 0, 0, 0, 4);
    v(0, 1, 1, 0, 4'h0, 0, 1, 0, 4);
    v(0, 1, 0, 0, 4'h0, 0, 2, 0, 4);
    v(0, 1, 1, 0, 4'h0, 0, 3, 0, 4);
    v(0, 1, 1, 0, 4'h0, 0, 4, 1, 5);
    v(0, 1, 0, 0, 4'h0, 0, 0, 0, 5);
    v(0, 1, 1, 0, 4'h0, 0, 1, 0, 5);
    v(0, 1, 1, 0, 4'h0, 0, 1, 0, 5);
    // en gaps hold; pat_load with en drops the sample
    v(0, 0, 0, 1, 4'hB, 1, 0, 0, 5);
    v(0, 1, 1, 0, 4'h0, 1, 1, 0, 5);
    v(0, 1, 0, 0, 4'h0, 1, 2, 0, 5);
    v(0, 1, 1, 0, 4'h0, 1, 3, 0, 5);
    v(0, 0, 0, 0, 4'h0, 1, 3, 0, 5);
    v(0, 0, 1, 0, 4'h0, 1, 3, 0, 5);
    v(0, 0, 0, 0, 4'h0, 1, 3, 0, 5);
    v(0, 1, 1, 1, 4'hB, 1, 0, 0, 5);
    v(0, 1, 1, 0, 4'h0, 1, 1, 0, 5);
    v(0, 1, 0, 0, 4'h0, 1, 2, 0, 5);
    v(0, 1, 1, 0, 4'h0, 1, 3, 0, 5);
    v(0, 1, 1, 0, 4'h0, 1, 4, 1, 6);
    v(0, 0, 0, 0, 4'h0, 1, 4, 1, 6);
    v(0, 0, 1, 0, 4'h0, 1, 4, 1, 6);
    v(0, 1, 1, 0, 4'h0, 1, 1, 0, 6);
    // mid-match reset beats pat_load and en, pattern returns to 0000
    v(0, 0, 0, 1, 4'hB, 1, 0, 0, 6);
    v(0, 1, 1, 0, 4'h0, 1, 1, 0, 6);
    v(0, 1, 0, 0, 4'h0, 1, 2, 0, 6);
    v(0, 1, 1, 0, 4'h0, 1, 3, 0, 6);
    v(1, 1, 1, 1, 4'hF, 1, 0, 0, 0);
    v(0, 1, 0, 0, 4'h0, 1, 1, 0, 0);
    v(0, 1, 0, 0, 4'h0, 1, 2, 0, 0);
    v(0, 1, 0, 0, 4'h0, 1, 3, 0, 0);
    v(0, 1, 0, 0, 4'h0, 1, 4, 1, 1);

    foreach (vecs[i]) begin
      rst_a          = vecs[i].rst;
      bus_a.en       = vecs[i].en;
      bus_a.seq      = vecs[i].seq;
      bus_a.pat_load = vecs[i].pl;
      bus_a.pattern  = vecs[i].pat;
      bus_a.overlap  = vecs[i].ov;
      @(posedge clk);
      #1;
      check($sformatf("row%0d match_len", i), int'(bus_a.match_len), vecs[i].ml);
      check($sformatf("row%0d detected", i), int'(bus_a.detected), vecs[i].det);
      check($sformatf("row%0d det_count", i), int'(bus_a.det_count),
            count_en ? vecs[i].cnt : 0);
      check($sformatf("row%0d count_sat", i), int'(bus_a.count_sat), 0);
    end

    // Saturation on a 2-bit counter: events at samples 4..10, saturates at sample 6.
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    check("sat reset det_count", int'(bus_b.det_count), 0);
    check("sat reset count_sat", int'(bus_b.count_sat), 0);
    for (int i = 1; i <= 10; i++) begin
      int exp_cnt;
      bus_b.en  = 1'b1;
      bus_b.seq = 1'b0;
      @(posedge clk);
      #1;
      exp_cnt = (i < 4) ? 0 : ((i - 3 > 3) ? 3 : i - 3);
      check($sformatf("sat s%0d match_len", i), int'(bus_b.match_len), (i < 4) ? i : 4);
      check($sformatf("sat s%0d det_count", i), int'(bus_b.det_count),
            count_en ? exp_cnt : 0);
      check($sformatf("sat s%0d count_sat", i), int'(bus_b.count_sat),
            (count_en && i >= 6) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
